// File: rtl/sar_adc_ctrl_if.sv
// Start-of-conversion handshake, DAC trial code and comparator bundle
// between the SAR controller (slave) and its consumer/analog front end (master).
interface sar_adc_ctrl_if;
  logic       soc;
  logic       eoc;
  logic [7:0] x;
  logic [7:0] dac;
  logic       cmp;

  modport master (
    output soc,
    output cmp,
    input  eoc,
    input  x,
    input  dac
  );

  modport slave (
    input  soc,
    input  cmp,
    output eoc,
    output x,
    output dac
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation converter controller: answers a soc/eoc handshake,
// resolves one bit per settle window (MSB first) through an external DAC and
// comparator, and publishes the 8-bit result on x when eoc rises.
module sar_adc_ctrl #(
  parameter int unsigned SETTLE = 2  // cycles each trial code is held; 1..16
) (
  input  logic           clock,
  input  logic           reset,
  sar_adc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] trial_q, trial_d;
  logic [7:0] x_q, x_d;
  logic       eoc_q, eoc_d;

  // State register; reset aborts any conversion and re-arms idle immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 3'd7;
      cnt_q   <= '0;
      trial_q <= '0;
      x_q     <= '0;
      eoc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      trial_q <= trial_d;
      x_q     <= x_d;
      eoc_q   <= eoc_d;
    end
  end

  // Next-state logic: settle countdown, bit judgement, and the soc/eoc handshake.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    trial_d = trial_q;
    x_d     = x_q;
    eoc_d   = eoc_q;

    case (state_q)
      IDLE: begin
        if (bus.soc) begin
          eoc_d   = 1'b0;
          trial_d = 8'h80;
          k_d     = 3'd7;
          cnt_d   = CNT_LOAD;
          state_d = CONV;
        end
      end

      CONV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Keep or clear the bit under trial, then tentatively set the next one.
          trial_d[k_q] = bus.cmp;
          if (k_q != '0) begin
            trial_d[k_q - 3'd1] = 1'b1;
            k_d                 = k_q - 3'd1;
            cnt_d               = CNT_LOAD;
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        // Completion waits for soc to drop so a held request cannot retrigger.
        if (!bus.soc) begin
          x_d     = trial_q;
          eoc_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.eoc = eoc_q;
  assign bus.x   = x_q;
  assign bus.dac = trial_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: one instance with SETTLE=2 and one with SETTLE=1,
// an ideal comparator model, directed conversions, and an eoc-driven scoreboard.
module tb_sar_adc_ctrl;

  logic clk;
  logic rst;

  logic       soc_r [2];
  logic [7:0] vin_r [2];
  logic       eoc_w [2];
  logic [7:0] x_w   [2];
  logic [7:0] dac_w [2];

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  logic       prev0 = 1'b1;
  logic       prev1 = 1'b1;
  logic [7:0] e0;
  logic [7:0] e1;

  logic [7:0] seq_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  sar_adc_ctrl_if if0 ();
  sar_adc_ctrl_if if1 ();

  sar_adc_ctrl #(.SETTLE(2)) u_dut2 (.clock(clk), .reset(rst), .bus(if0));
  sar_adc_ctrl #(.SETTLE(1)) u_dut1 (.clock(clk), .reset(rst), .bus(if1));

  assign if0.soc  = soc_r[0];
  assign if1.soc  = soc_r[1];
  assign if0.cmp  = (vin_r[0] >= if0.dac);
  assign if1.cmp  = (vin_r[1] >= if1.dac);
  assign eoc_w[0] = if0.eoc;
  assign eoc_w[1] = if1.eoc;
  assign x_w[0]   = if0.x;
  assign x_w[1]   = if1.x;
  assign dac_w[0] = if0.dac;
  assign dac_w[1] = if1.dac;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every eoc rise outside reset presents a result.
  always @(negedge clk) begin
    if (!rst && eoc_w[0] === 1'b1 && !prev0) begin
      if (exp_q0.size() == 0) begin
        check_int("sb0_unexpected", 1, 0);
      end else begin
        e0 = exp_q0.pop_front();
        check("sb0_x", x_w[0], e0);
      end
    end
    prev0 <= (eoc_w[0] === 1'b1);
  end

  always @(negedge clk) begin
    if (!rst && eoc_w[1] === 1'b1 && !prev1) begin
      if (exp_q1.size() == 0) begin
        check_int("sb1_unexpected", 1, 0);
      end else begin
        e1 = exp_q1.pop_front();
        check("sb1_x", x_w[1], e1);
      end
    end
    prev1 <= (eoc_w[1] === 1'b1);
  end

  // soc level to present before edge E0+n.
  function automatic logic pat(input int n, input int hold, input bit toggle);
    if (toggle) return (n < 10) && (n % 2 == 1);
    return n < hold;
  endfunction

  task automatic run_conv(input int d, input logic [7:0] vin, input logic [7:0] expx,
                          input int hold, input bit toggle, input int exp_edges,
                          input bit chk_seq);
    int n;
    vin_r[d] = vin;
    if (d == 0) exp_q0.push_back(expx);
    else        exp_q1.push_back(expx);
    @(posedge clk); #1;
    soc_r[d] = 1'b1;
    @(posedge clk); #1;  // E0
    check("eoc_ack", {7'd0, eoc_w[d]}, 8'h00);
    check("dac_first", dac_w[d], 8'h80);
    n = 0;
    soc_r[d] = pat(1, hold, toggle);
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (eoc_w[d] === 1'b1) break;
      if (chk_seq && n < 16) check("dac_step", dac_w[d], seq_a5[n / 2]);
      soc_r[d] = pat(n + 1, hold, toggle);
    end
    soc_r[d] = 1'b0;
    check_int("latency", n, exp_edges);
    repeat (3) @(posedge clk);
    #1;
    check("x_hold", x_w[d], expx);
    check("dac_hold", dac_w[d], expx);
  endtask

  int sum;

  initial begin
    rst      = 1'b0;
    soc_r[0] = 1'b0;
    soc_r[1] = 1'b0;
    vin_r[0] = 8'h00;
    vin_r[1] = 8'h00;

    // Mid-cycle asynchronous reset.
    #12 rst = 1'b1;
    #1;
    check("rst_eoc0", {7'd0, eoc_w[0]}, 8'h01);
    check("rst_x0",   x_w[0],   8'h00);
    check("rst_dac0", dac_w[0], 8'h00);
    check("rst_eoc1", {7'd0, eoc_w[1]}, 8'h01);
    check("rst_x1",   x_w[1],   8'h00);
    #19 rst = 1'b0;

    // Main conversion with full dac step trace, soc high for two cycles.
    run_conv(0, 8'hA5, 8'hA5, 2, 1'b0, 17, 1'b1);

    // Extremes at SETTLE=1.
    run_conv(1, 8'h00, 8'h00, 1, 1'b0, 9, 1'b0);
    run_conv(1, 8'hFF, 8'hFF, 1, 1'b0, 9, 1'b0);

    // soc held 30 cycles: stalls in FIN, completes one edge after soc low.
    run_conv(0, 8'h3C, 8'h3C, 30, 1'b0, 30, 1'b0);

    // soc toggling during CONV has no effect.
    run_conv(0, 8'h96, 8'h96, 0, 1'b1, 17, 1'b0);

    // Reset at E0+6 aborts an 0xA5 conversion.
    vin_r[0] = 8'hA5;
    @(posedge clk); #1;
    soc_r[0] = 1'b1;
    @(posedge clk); #1;  // E0
    soc_r[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_eoc", {7'd0, eoc_w[0]}, 8'h01);
    check("abort_x",   x_w[0],   8'h00);
    check("abort_dac", dac_w[0], 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    run_conv(0, 8'h5A, 8'h5A, 1, 1'b0, 17, 1'b0);

    // Threshold-averaging consumer: three back-to-back handshakes.
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      run_conv(0, 8'h37, 8'h37, 1, 1'b0, 17, 1'b0);
      sum += int'(x_w[0]);
    end
    check_int("consumer_sum", sum, 165);
    check_int("consumer_out", (sum >= 164) ? 1 : 0, 1);

    repeat (2) @(posedge clk);
    check_int("sb_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
